// File: rtl/asym_sdp_buffer.sv
// Asymmetric simple dual-port buffer on a single clock.
// Narrow write port and wide read port. Each read word holds RATIO write lanes.
// The array has no reset so it can map onto block RAM. Only the read pipeline
// and its valid bits are reset.
module asym_sdp_buffer #(
   parameter int unsigned WRITE_WIDTH  = 8,
   parameter int unsigned RATIO        = 4,
   parameter int unsigned BUFFER_DEPTH = 128,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned BYTE_EN      = 0,
   localparam int unsigned READ_WIDTH  = WRITE_WIDTH * RATIO,
   localparam int unsigned RAW         = $clog2(BUFFER_DEPTH),
   localparam int unsigned WAW         = RAW + $clog2(RATIO),
   localparam int unsigned SW          = (BYTE_EN != 0) ? WRITE_WIDTH / 8 : 1
) (
   input  logic                  clka,
   input  logic                  rstb,
   input  logic                  wr_en,
   input  logic [WAW-1:0]        wr_addr,
   input  logic [WRITE_WIDTH-1:0] wr_data,
   input  logic [SW-1:0]         wr_strb,
   input  logic                  rd_en,
   input  logic [RAW-1:0]        rd_addr,
   input  logic                  rd_regce,
   output logic [READ_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  wr_oob
);

   localparam int unsigned LB  = $clog2(RATIO);
   // Write granule: a byte with strobes, otherwise a whole lane.
   localparam int unsigned GW  = (BYTE_EN != 0) ? 8 : WRITE_WIDTH;
   localparam int unsigned GPL = WRITE_WIDTH / GW;
   localparam int unsigned NG  = READ_WIDTH / GW;
   localparam logic [RAW:0] DEPTH_V = BUFFER_DEPTH[RAW:0];

   logic [READ_WIDTH-1:0] mem [BUFFER_DEPTH];

   logic [RAW-1:0]        widx;
   logic [31:0]           wlane;
   logic                  wr_inrange;
   logic                  wr_go;
   logic [NG-1:0]         gwe;
   logic [READ_WIDTH-1:0] wdata_rep;
   logic                  wr_oob_q;

   logic                  rd_inrange;
   logic [READ_WIDTH-1:0] ram_q;
   logic                  s1_valid_q;
   logic                  s1_zero_q;
   logic [READ_WIDTH-1:0] s1_data;

   assign widx = wr_addr[WAW-1 -: RAW];

   if (RATIO > 1) begin : g_lane
      assign wlane = 32'(wr_addr[LB-1:0]);
   end else begin : g_nolane
      assign wlane = '0;
   end

   assign wr_inrange = {1'b0, widx} < DEPTH_V;
   // Writes are dropped while reset is held as well as when out of range.
   assign wr_go      = wr_en & rstb & wr_inrange;
   assign wdata_rep  = {RATIO{wr_data}};
   assign wr_oob     = wr_oob_q;

   // Per-granule write enables for the addressed lane.
   always_comb begin
      gwe = '0;
      for (int g = 0; g < NG; g++) begin
         if (wr_go && ((g / GPL) == wlane)) begin
            gwe[g] = (BYTE_EN != 0) ? wr_strb[g % GPL] : 1'b1;
         end
      end
   end

   // Array write port, no reset so it infers as block RAM.
   always_ff @(posedge clka) begin
      for (int g = 0; g < NG; g++) begin
         if (gwe[g]) begin
            mem[widx][g*GW +: GW] <= wdata_rep[g*GW +: GW];
         end
      end
   end

   // Sticky flag for discarded out-of-range writes.
   always_ff @(posedge clka or negedge rstb) begin
      if (!rstb) begin
         wr_oob_q <= 1'b0;
      end else if (wr_en && !wr_inrange) begin
         wr_oob_q <= 1'b1;
      end
   end

   assign rd_inrange = {1'b0, rd_addr} < DEPTH_V;

   // Array read register (stage 1); read-first against a same-edge write.
   always_ff @(posedge clka) begin
      if (rd_en && rd_inrange) begin
         ram_q <= mem[rd_addr];
      end
   end

   // Stage-1 valid plus a zero mask covering out-of-range reads and reset.
   always_ff @(posedge clka or negedge rstb) begin
      if (!rstb) begin
         s1_valid_q <= 1'b0;
         s1_zero_q  <= 1'b1;
      end else begin
         s1_valid_q <= rd_en;
         if (rd_en) begin
            s1_zero_q <= !rd_inrange;
         end
      end
   end

   assign s1_data = s1_zero_q ? '0 : ram_q;

   if (READ_LATENCY == 1) begin : g_lat1
      logic unused_regce;
      assign unused_regce = rd_regce;
      assign rd_data      = s1_data;
      assign rd_valid     = s1_valid_q;
   end else begin : g_pipe
      localparam int unsigned NP = READ_LATENCY - 1;

      logic [READ_WIDTH-1:0] pdata_q   [NP];
      logic [NP-1:0]         pvalid_q;
      logic [READ_WIDTH-1:0] pin_data  [NP];
      logic [NP-1:0]         pin_valid;

      // Input of each pipeline register: stage 1 feeds the first one.
      always_comb begin
         pin_data[0]  = s1_data;
         pin_valid[0] = s1_valid_q;
         for (int k = 1; k < NP; k++) begin
            pin_data[k]  = pdata_q[k-1];
            pin_valid[k] = pvalid_q[k-1];
         end
      end

      // Pipeline registers; the last one only loads under rd_regce.
      always_ff @(posedge clka or negedge rstb) begin
         if (!rstb) begin
            pvalid_q <= '0;
            for (int k = 0; k < NP; k++) begin
               pdata_q[k] <= '0;
            end
         end else begin
            for (int k = 0; k < NP - 1; k++) begin
               pvalid_q[k] <= pin_valid[k];
               if (pin_valid[k]) begin
                  pdata_q[k] <= pin_data[k];
               end
            end
            pvalid_q[NP-1] <= pin_valid[NP-1] & rd_regce;
            if (pin_valid[NP-1] && rd_regce) begin
               pdata_q[NP-1] <= pin_data[NP-1];
            end
         end
      end

      assign rd_data  = pdata_q[NP-1];
      assign rd_valid = pvalid_q[NP-1];
   end

endmodule

// File: tb/tb_asym_sdp_buffer.sv
// Self-checking bench for asym_sdp_buffer.
// Instances a (depth 16) and b (depth 12) share the 8-bit x4 write stimulus.
// Instance c is 16-bit x2 with byte strobes and three-cycle latency.
module tb_asym_sdp_buffer;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   logic        wr_en, rd_en, rd_regce;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [0:0]  wr_strb;
   logic [3:0]  rd_addr;
   logic        c_wr_en, c_rd_en, c_rd_regce;
   logic [3:0]  c_wr_addr;
   logic [15:0] c_wr_data;
   logic [1:0]  c_wr_strb;
   logic [2:0]  c_rd_addr;

   logic [31:0] od [3];
   logic [2:0]  ov, oo;

   asym_sdp_buffer #(.WRITE_WIDTH(8), .RATIO(4), .BUFFER_DEPTH(16), .READ_LATENCY(2),
      .BYTE_EN(0)) u_a (
      .clka(clk), .rstb(rstb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_regce(rd_regce),
      .rd_data(od[0]), .rd_valid(ov[0]), .wr_oob(oo[0]));

   asym_sdp_buffer #(.WRITE_WIDTH(8), .RATIO(4), .BUFFER_DEPTH(12), .READ_LATENCY(2),
      .BYTE_EN(0)) u_b (
      .clka(clk), .rstb(rstb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_regce(rd_regce),
      .rd_data(od[1]), .rd_valid(ov[1]), .wr_oob(oo[1]));

   asym_sdp_buffer #(.WRITE_WIDTH(16), .RATIO(2), .BUFFER_DEPTH(8), .READ_LATENCY(3),
      .BYTE_EN(1)) u_c (
      .clka(clk), .rstb(rstb), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
      .wr_strb(c_wr_strb), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_regce(c_rd_regce),
      .rd_data(od[2]), .rd_valid(ov[2]), .wr_oob(oo[2]));

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: plain word arrays plus queues of pending read results.
   typedef struct { logic [1:0][31:0] d; int done; } ab_ent_t;
   typedef struct { logic [31:0] d; int done; } c_ent_t;
   logic [31:0] m_ab [2][16];
   logic [31:0] m_c [8];
   int          dep [2] = '{16, 12};
   ab_ent_t     q_ab [$];
   c_ent_t      q_c [$];
   int          ecnt = 0;
   logic [31:0] exp_d [3];
   logic [2:0]  exp_v, exp_oob;
   logic [7:0]  fb [48];
   logic [15:0] fc [16];

   function automatic void model_reset();
      q_ab.delete();
      q_c.delete();
      for (int i = 0; i < 3; i++) exp_d[i] = '0;
      exp_v = '0;
      exp_oob = '0;
   endfunction

   // Applies one clock edge to the model using the inputs currently driven.
   function automatic void model_edge();
      ab_ent_t ea;
      c_ent_t  ec;
      int idx, ln;
      if (!rstb) return;
      ecnt++;
      if (rd_en) begin
         for (int i = 0; i < 2; i++)
            ea.d[i] = (int'(rd_addr) < dep[i]) ? m_ab[i][rd_addr] : 32'h0;
         ea.done = ecnt + 1;
         q_ab.push_back(ea);
      end
      if (c_rd_en) begin
         ec.d = m_c[c_rd_addr];
         ec.done = ecnt + 2;
         q_c.push_back(ec);
      end
      if (wr_en) begin
         idx = int'(wr_addr) / 4;
         ln  = int'(wr_addr) % 4;
         for (int i = 0; i < 2; i++) begin
            if (idx < dep[i]) m_ab[i][idx][ln*8 +: 8] = wr_data;
            else exp_oob[i] = 1'b1;
         end
      end
      if (c_wr_en) begin
         idx = int'(c_wr_addr) / 2;
         ln  = int'(c_wr_addr) % 2;
         for (int b = 0; b < 2; b++)
            if (c_wr_strb[b]) m_c[idx][ln*16 + b*8 +: 8] = c_wr_data[b*8 +: 8];
      end
      exp_v = '0;
      if (q_ab.size() > 0 && q_ab[0].done == ecnt) begin
         ea = q_ab.pop_front();
         if (rd_regce) begin
            for (int i = 0; i < 2; i++) begin
               exp_v[i] = 1'b1;
               exp_d[i] = ea.d[i];
            end
         end
      end
      if (q_c.size() > 0 && q_c[0].done == ecnt) begin
         ec = q_c.pop_front();
         if (c_rd_regce) begin
            exp_v[2] = 1'b1;
            exp_d[2] = ec.d;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
      rd_en = 0; rd_addr = '0; rd_regce = 1;
      c_wr_en = 0; c_wr_addr = '0; c_wr_data = '0; c_wr_strb = '0;
      c_rd_en = 0; c_rd_addr = '0; c_rd_regce = 1;
   endtask

   function automatic logic [31:0] wfb(int k);
      return {fb[4*k+3], fb[4*k+2], fb[4*k+1], fb[4*k]};
   endfunction

   task automatic test_reset();
      idle();
      rstb = 0;
      model_reset();
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (od[i] !== 32'h0) begin n_fail++;
            $display("FAIL reset_data[%0d] got %h want 0", i, od[i]); end
         n_chk++; if (ov[i] !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid[%0d] got %b want 0", i, ov[i]); end
         n_chk++; if (oo[i] !== 1'b0) begin n_fail++;
            $display("FAIL reset_oob[%0d] got %b want 0", i, oo[i]); end
      end
      rstb = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (ov[i] !== 1'b0) begin n_fail++;
            $display("FAIL post_release_valid[%0d] got %b want 0", i, ov[i]); end
      end
   endtask

   task automatic test_lane_packing();
      wr_en = 1;
      for (int k = 0; k < 4; k++) begin
         wr_addr = 6'(8 + k);
         wr_data = 8'(8'h11 * (k + 1));
         tick();
      end
      wr_en = 0;
      rd_en = 1; rd_addr = 4'd2;
      tick();
      rd_en = 0;
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (ov[i] !== 1'b0) begin n_fail++;
            $display("FAIL lane_early_valid[%0d] got %b want 0", i, ov[i]); end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (ov[i] !== 1'b1 || od[i] !== 32'h44332211) begin n_fail++;
            $display("FAIL lane_pack[%0d] got v=%b d=%h want v=1 d=44332211", i, ov[i], od[i]);
         end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (ov[i] !== 1'b0 || od[i] !== 32'h44332211) begin n_fail++;
            $display("FAIL lane_hold[%0d] got v=%b d=%h want v=0 d=44332211", i, ov[i], od[i]);
         end
      end
   endtask

   task automatic test_collision();
      wr_en = 1; wr_addr = 6'd8; wr_data = 8'hAA;
      rd_en = 1; rd_addr = 4'd2;
      tick();
      wr_en = 0;
      tick();
      rd_en = 0;
      n_chk++; if (ov[0] !== 1'b1 || od[0] !== 32'h44332211) begin n_fail++;
         $display("FAIL collision_old got v=%b d=%h want v=1 d=44332211", ov[0], od[0]); end
      tick();
      n_chk++; if (ov[0] !== 1'b1 || od[0] !== 32'h443322AA) begin n_fail++;
         $display("FAIL collision_new got v=%b d=%h want v=1 d=443322aa", ov[0], od[0]); end
   endtask

   task automatic test_regce_stream();
      int          cnt [2];
      logic [31:0] seen [2][4];
      wr_en = 1;
      for (int a = 0; a < 48; a++) begin
         fb[a] = 8'($urandom);
         wr_addr = 6'(a);
         wr_data = fb[a];
         tick();
      end
      wr_en = 0;
      cnt = '{0, 0};
      for (int e = 0; e < 7; e++) begin
         rd_en = (e < 4);
         rd_addr = 4'(e);
         rd_regce = (e != 3);
         tick();
         for (int i = 0; i < 2; i++) begin
            if (ov[i] && cnt[i] < 4) begin seen[i][cnt[i]] = od[i]; cnt[i]++; end
            if (e == 3) begin
               n_chk++; if (ov[i] !== 1'b0 || od[i] !== wfb(1)) begin n_fail++;
                  $display("FAIL regce_gap[%0d] got v=%b d=%h want v=0 d=%h", i, ov[i], od[i],
                     wfb(1)); end
            end
         end
      end
      idle();
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (cnt[i] != 3) begin n_fail++;
            $display("FAIL regce_pulses[%0d] got %0d want 3", i, cnt[i]); end
         if (cnt[i] == 3) begin
            n_chk++; if (seen[i][0] !== wfb(0) || seen[i][1] !== wfb(1) ||
                         seen[i][2] !== wfb(3)) begin n_fail++;
               $display("FAIL regce_order[%0d] got %h %h %h want %h %h %h", i, seen[i][0],
                  seen[i][1], seen[i][2], wfb(0), wfb(1), wfb(3)); end
         end
      end
   endtask

   task automatic test_out_of_range();
      n_chk++; if (oo[1] !== 1'b0) begin n_fail++;
         $display("FAIL oob_initial got %b want 0", oo[1]); end
      wr_en = 1; wr_addr = 6'd48; wr_data = 8'h5A;
      tick();
      wr_en = 0;
      n_chk++; if (oo[1] !== 1'b1 || oo[0] !== 1'b0) begin n_fail++;
         $display("FAIL oob_set got b=%b a=%b want b=1 a=0", oo[1], oo[0]); end
      tick();
      n_chk++; if (oo[1] !== 1'b1) begin n_fail++;
         $display("FAIL oob_sticky got %b want 1", oo[1]); end
      rd_en = 1; rd_addr = 4'd13;
      tick();
      rd_addr = 4'd12;
      tick();
      rd_addr = 4'd0;
      n_chk++; if (ov[1] !== 1'b1 || od[1] !== 32'h0) begin n_fail++;
         $display("FAIL oob_read13 got v=%b d=%h want v=1 d=0", ov[1], od[1]); end
      tick();
      rd_en = 0;
      n_chk++; if (ov[1] !== 1'b1 || od[1] !== 32'h0) begin n_fail++;
         $display("FAIL oob_read12 got v=%b d=%h want v=1 d=0", ov[1], od[1]); end
      n_chk++; if (ov[0] !== 1'b1 || od[0][7:0] !== 8'h5A) begin n_fail++;
         $display("FAIL inrange_word12 got v=%b d=%h want v=1 lane0=5a", ov[0], od[0]); end
      tick();
      n_chk++; if (od[1] !== wfb(0) || od[0] !== wfb(0)) begin n_fail++;
         $display("FAIL oob_unchanged got b=%h a=%h want %h", od[1], od[0], wfb(0)); end
   endtask

   task automatic test_byte_strobes();
      c_wr_en = 1; c_wr_strb = 2'b11;
      for (int a = 0; a < 16; a++) begin
         fc[a] = 16'($urandom);
         c_wr_addr = 4'(a);
         c_wr_data = fc[a];
         tick();
      end
      c_wr_addr = 4'd5;
      c_wr_data = 16'hBEEF; c_wr_strb = 2'b11; tick();
      c_wr_data = 16'h1234; c_wr_strb = 2'b10; tick();
      c_wr_data = 16'hFFFF; c_wr_strb = 2'b00; tick();
      c_wr_en = 0;
      c_rd_en = 1; c_rd_addr = 3'd2;
      tick();
      c_rd_en = 0;
      n_chk++; if (ov[2] !== 1'b0) begin n_fail++;
         $display("FAIL strb_lat1 got %b want 0", ov[2]); end
      tick();
      n_chk++; if (ov[2] !== 1'b0) begin n_fail++;
         $display("FAIL strb_lat2 got %b want 0", ov[2]); end
      tick();
      n_chk++; if (ov[2] !== 1'b1 || od[2] !== {16'h12EF, fc[4]}) begin n_fail++;
         $display("FAIL strb_merge got v=%b d=%h want v=1 d=%h", ov[2], od[2],
            {16'h12EF, fc[4]}); end
   endtask

   task automatic test_reset_midflight();
      rd_en = 1; rd_addr = 4'd2;
      c_rd_en = 1; c_rd_addr = 3'd2;
      tick();
      rd_en = 0; c_rd_en = 0;
      #2;
      rstb = 0;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (od[i] !== 32'h0 || ov[i] !== 1'b0 || oo[i] !== 1'b0) begin n_fail++;
            $display("FAIL async_reset[%0d] got d=%h v=%b oob=%b want 0 0 0", i, od[i], ov[i],
               oo[i]); end
      end
      wr_en = 1; wr_addr = 6'd8; wr_data = ~fb[8];
      c_wr_en = 1; c_wr_addr = 4'd4; c_wr_data = ~fc[4]; c_wr_strb = 2'b11;
      tick();
      tick();
      idle();
      rstb = 1;
      for (int e = 0; e < 4; e++) begin
         tick();
         n_chk++; if (ov !== 3'b000) begin n_fail++;
            $display("FAIL stale_pulse cycle %0d got %b want 000", e, ov); end
      end
      rd_en = 1; rd_addr = 4'd2;
      c_rd_en = 1; c_rd_addr = 3'd2;
      tick();
      idle();
      tick();
      n_chk++; if (ov[0] !== 1'b1 || od[0] !== wfb(2)) begin n_fail++;
         $display("FAIL reset_wr_ignored got v=%b d=%h want v=1 d=%h", ov[0], od[0], wfb(2));
      end
      tick();
      n_chk++; if (ov[2] !== 1'b1 || od[2] !== {16'h12EF, fc[4]}) begin n_fail++;
         $display("FAIL reset_wr_ignored_c got v=%b d=%h want v=1 d=%h", ov[2], od[2],
            {16'h12EF, fc[4]}); end
   endtask

   task automatic test_random();
      wr_en = 1;
      for (int a = 0; a < 64; a++) begin
         wr_addr = 6'(a); wr_data = 8'($urandom); tick();
      end
      wr_en = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         wr_en = 1'($urandom); wr_addr = 6'($urandom); wr_data = 8'($urandom);
         rd_en = ($urandom_range(0, 3) != 0); rd_addr = 4'($urandom);
         rd_regce = ($urandom_range(0, 3) != 0);
         c_wr_en = 1'($urandom); c_wr_addr = 4'($urandom); c_wr_data = 16'($urandom);
         c_wr_strb = 2'($urandom);
         c_rd_en = ($urandom_range(0, 3) != 0); c_rd_addr = 3'($urandom);
         c_rd_regce = ($urandom_range(0, 3) != 0);
         tick();
         for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (ov[i] !== exp_v[i] || od[i] !== exp_d[i] || oo[i] !== exp_oob[i]) begin
               n_fail++;
               $display("FAIL random[%0d] cycle %0d got v=%b d=%h oob=%b want v=%b d=%h oob=%b",
                  i, cyc, ov[i], od[i], oo[i], exp_v[i], exp_d[i], exp_oob[i]);
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_lane_packing();
      test_collision();
      test_regce_stream();
      test_out_of_range();
      test_byte_strobes();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached after %0d checks", n_chk);
      $fatal(1);
   end

endmodule
